pe_column_mac: RTL and testbench

- Parametrised successor to the fixed 4-PE column in the LeNet PE array.
- N_ROWS MAC lanes share one broadcast weight stream; each lane has its own feature-map input.
- Each lane accumulates a KERNEL_LEN-tap window, then adds a chained partial sum from the upstream column plus an optional bias.
- Each lane emits a saturated wide partial sum and a requantised DATA_W result, and forwards its map input one cycle later to the neighbouring column.

---
 rtl/pe_column_mac_if.sv | 33 +++
 rtl/pe_column_mac.sv | 142 ++++++++++++++
 tb/tb_pe_column_mac.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pe_column_mac_if.sv
// Bus bundle for one pe_column_mac column: tap stream, chained partial sums and results.
// The master side drives taps and upstream sums; the slave side is the column itself.
interface pe_column_mac_if #(
  parameter int N_ROWS = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);
  logic                       clear;
  logic [DATA_W-1:0]          weight_in;
  logic                       weight_vld;
  logic [N_ROWS*DATA_W-1:0]   map_in;
  logic [N_ROWS-1:0]          map_vld;
  logic                       tap_rdy;
  logic [N_ROWS*ACC_W-1:0]    psum_in;
  logic                       psum_vld;
  logic                       add_bias;
  logic [DATA_W-1:0]          bias;
  logic [N_ROWS*DATA_W-1:0]   map_out;
  logic [N_ROWS-1:0]          map_out_vld;
  logic [N_ROWS*ACC_W-1:0]    psum_out;
  logic [N_ROWS*DATA_W-1:0]   dout;
  logic                       out_vld;

  modport master (
    output clear, weight_in, weight_vld, map_in, map_vld, psum_in, psum_vld, add_bias, bias,
    input  tap_rdy, map_out, map_out_vld, psum_out, dout, out_vld
  );

  modport slave (
    input  clear, weight_in, weight_vld, map_in, map_vld, psum_in, psum_vld, add_bias, bias,
    output tap_rdy, map_out, map_out_vld, psum_out, dout, out_vld
  );
endinterface

// File: rtl/pe_column_mac.sv
// Column of N_ROWS MAC lanes sharing a weight stream; accumulates KERNEL_LEN taps, adds the
// upstream partial sum and optional bias, then saturates and requantises. Macro PE_COLUMN_RELU_EN fuses a ReLU.
module pe_column_mac #(
  parameter int N_ROWS     = 4,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 24,
  parameter int KERNEL_LEN = 25,
  parameter int FRAC_BITS  = 4
) (
  input  logic              clk_cal,
  input  logic              rst_cal,
  pe_column_mac_if.slave    bus
);

  localparam int CNT_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam int EXT_W = ACC_W + 2;

  typedef enum logic {ST_ACC, ST_SUM} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         tap_cnt_q;
  logic                     tap_rdy, fire, last_tap, sum_go;

  logic signed [ACC_W-1:0]    acc_q    [N_ROWS];
  logic signed [2*DATA_W-1:0] prod     [N_ROWS];
  logic signed [ACC_W-1:0]    acc_step [N_ROWS];
  logic signed [EXT_W-1:0]    sum_full [N_ROWS];
  logic signed [ACC_W-1:0]    sum_sat  [N_ROWS];
  logic signed [DATA_W-1:0]   dout_d   [N_ROWS];
  logic signed [EXT_W-1:0]    bias_add;

  logic [N_ROWS*DATA_W-1:0] map_out_q;
  logic [N_ROWS-1:0]        map_vld_q;
  logic [N_ROWS*ACC_W-1:0]  psum_out_q;
  logic [N_ROWS*DATA_W-1:0] dout_q;
  logic                     out_vld_q;

  // Inputs carry two guard bits beyond ACC_W, enough for acc + psum + bias without wrap.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [EXT_W-1:0] v);
    if (v[EXT_W-1:ACC_W-1] == {3{v[EXT_W-1]}})
      return v[ACC_W-1:0];
    else if (v[EXT_W-1])
      return {1'b1, {(ACC_W-1){1'b0}}};
    else
      return {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){v[ACC_W-1]}})
      return v[DATA_W-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  function automatic logic signed [2*DATA_W-1:0] mul(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return a * b;
  endfunction

  always_comb begin
    state_d  = state_q;
    tap_rdy  = (state_q == ST_ACC);
    fire     = tap_rdy & bus.weight_vld & (&bus.map_vld);
    last_tap = (tap_cnt_q == CNT_W'(KERNEL_LEN - 1));
    sum_go   = (state_q == ST_SUM) & bus.psum_vld;
    if (bus.clear)
      state_d = ST_ACC;
    else if (fire && last_tap)
      state_d = ST_SUM;
    else if (sum_go)
      state_d = ST_ACC;
  end

  always_ff @(posedge clk_cal or negedge rst_cal) begin
    if (!rst_cal)
      state_q <= ST_ACC;
    else
      state_q <= state_d;
  end

  // Per-lane datapath: next accumulate value and the finished window result.
  always_comb begin
    bias_add = '0;
    if (bus.add_bias)
      bias_add = EXT_W'(signed'(bus.bias)) <<< FRAC_BITS;
    for (int r = 0; r < N_ROWS; r++) begin
      prod[r]     = mul(signed'(bus.weight_in), signed'(bus.map_in[r*DATA_W +: DATA_W]));
      acc_step[r] = sat_acc(EXT_W'(acc_q[r]) + EXT_W'(prod[r]));
      sum_full[r] = EXT_W'(acc_q[r]) + EXT_W'(signed'(bus.psum_in[r*ACC_W +: ACC_W])) + bias_add;
      sum_sat[r]  = sat_acc(sum_full[r]);
`ifdef PE_COLUMN_RELU_EN
      if (sum_sat[r][ACC_W-1])
        sum_sat[r] = '0;
`endif
      dout_d[r]   = sat_data(sum_sat[r] >>> FRAC_BITS);
    end
  end

  // clear outranks both a tap fire and the SUM step; map forwarding ignores it.
  always_ff @(posedge clk_cal or negedge rst_cal) begin
    if (!rst_cal) begin
      for (int r = 0; r < N_ROWS; r++)
        acc_q[r] <= '0;
      tap_cnt_q  <= '0;
      map_out_q  <= '0;
      map_vld_q  <= '0;
      psum_out_q <= '0;
      dout_q     <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      map_out_q <= bus.map_in;
      map_vld_q <= bus.map_vld;
      out_vld_q <= 1'b0;
      if (bus.clear) begin
        for (int r = 0; r < N_ROWS; r++)
          acc_q[r] <= '0;
        tap_cnt_q <= '0;
      end else if (fire) begin
        for (int r = 0; r < N_ROWS; r++)
          acc_q[r] <= acc_step[r];
        tap_cnt_q <= last_tap ? '0 : tap_cnt_q + CNT_W'(1);
      end else if (sum_go) begin
        for (int r = 0; r < N_ROWS; r++) begin
          acc_q[r]                         <= '0;
          psum_out_q[r*ACC_W +: ACC_W]     <= sum_sat[r];
          dout_q[r*DATA_W +: DATA_W]       <= dout_d[r];
        end
        out_vld_q <= 1'b1;
      end
    end
  end

  assign bus.tap_rdy     = tap_rdy;
  assign bus.map_out     = map_out_q;
  assign bus.map_out_vld = map_vld_q;
  assign bus.psum_out    = psum_out_q;
  assign bus.dout        = dout_q;
  assign bus.out_vld     = out_vld_q;

endmodule

// File: tb/tb_pe_column_mac.sv
// Directed bench for pe_column_mac: a 3-tap column for window/control cases and a 25-tap column
// for saturation. Expectations follow PE_COLUMN_RELU_EN when it is defined.
module tb_pe_column_mac;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 24;

`ifdef PE_COLUMN_RELU_EN
  localparam int NEG_PSUM = 0;
  localparam int NEG_DOUT = 0;
  localparam int SATN_PSUM = 0;
  localparam int SATN_DOUT = 0;
`else
  localparam int NEG_PSUM = -9;
  localparam int NEG_DOUT = -1;
  localparam int SATN_PSUM = -8388608;
  localparam int SATN_DOUT = -128;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pe_column_mac_if #(.N_ROWS(N), .DATA_W(DW), .ACC_W(AW)) bus3 ();
  pe_column_mac_if #(.N_ROWS(N), .DATA_W(DW), .ACC_W(AW)) bus25 ();

  pe_column_mac #(.N_ROWS(N), .DATA_W(DW), .ACC_W(AW), .KERNEL_LEN(3), .FRAC_BITS(4)) dut_k3 (
    .clk_cal (clk),
    .rst_cal (rst_n),
    .bus     (bus3)
  );

  pe_column_mac #(.N_ROWS(N), .DATA_W(DW), .ACC_W(AW), .KERNEL_LEN(25), .FRAC_BITS(4)) dut_k25 (
    .clk_cal (clk),
    .rst_cal (rst_n),
    .bus     (bus25)
  );

  task automatic check_output(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus3.clear = 1'b0;  bus3.weight_in = '0;  bus3.weight_vld = 1'b0; bus3.map_in = '0;
    bus3.map_vld = '0;  bus3.psum_in = '0;    bus3.psum_vld = 1'b0;   bus3.add_bias = 1'b0;
    bus3.bias = '0;
    bus25.clear = 1'b0; bus25.weight_in = '0; bus25.weight_vld = 1'b0; bus25.map_in = '0;
    bus25.map_vld = '0; bus25.psum_in = '0;   bus25.psum_vld = 1'b0;   bus25.add_bias = 1'b0;
    bus25.bias = '0;
  endtask

  task automatic apply_stimulus(input int w, input int m, input int p, input bit ab, input int b);
    bus3.weight_in = 8'(w);
    bus3.map_in    = {N{8'(m)}};
    bus3.psum_in   = {N{24'(p)}};
    bus3.add_bias  = ab;
    bus3.bias      = 8'(b);
  endtask

  task automatic window3(input string tag, input int w, input int m, input int p, input int stall,
                         input bit ab, input int b, input int exp_psum, input int exp_dout);
    @(negedge clk);
    apply_stimulus(w, m, p, ab, b);
    bus3.weight_vld = 1'b1;
    bus3.map_vld    = '1;
    bus3.psum_vld   = (stall == 0);
    repeat (3) @(negedge clk);
    bus3.weight_vld = 1'b0;
    check_output({tag, "/tap_rdy_in_sum"}, bus3.tap_rdy, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_output({tag, "/stall_out_vld"}, bus3.out_vld, 0);
      check_output({tag, "/stall_tap_rdy"}, bus3.tap_rdy, 0);
      check_output({tag, "/stall_map_fwd"}, bus3.map_out_vld, 4'hF);
    end
    bus3.psum_vld = 1'b1;
    @(negedge clk);
    check_output({tag, "/out_vld"}, bus3.out_vld, 1);
    for (int r = 0; r < N; r++) begin
      check_output($sformatf("%s/psum%0d", tag, r), $signed(bus3.psum_out[r*AW +: AW]), exp_psum);
      check_output($sformatf("%s/dout%0d", tag, r), $signed(bus3.dout[r*DW +: DW]), exp_dout);
    end
    bus3.psum_vld = 1'b0;
    bus3.add_bias = 1'b0;
    @(negedge clk);
    check_output({tag, "/pulse_end"}, bus3.out_vld, 0);
    check_output({tag, "/tap_rdy_back"}, bus3.tap_rdy, 1);
    check_output({tag, "/psum_hold"}, $signed(bus3.psum_out[AW-1:0]), exp_psum);
  endtask

  task automatic window25(input string tag, input int w, input int m, input int p,
                          input int exp_psum, input int exp_dout);
    @(negedge clk);
    bus25.weight_in  = 8'(w);
    bus25.map_in     = {N{8'(m)}};
    bus25.psum_in    = {N{24'(p)}};
    bus25.weight_vld = 1'b1;
    bus25.map_vld    = '1;
    bus25.psum_vld   = 1'b1;
    repeat (25) @(negedge clk);
    bus25.weight_vld = 1'b0;
    check_output({tag, "/no_early_out"}, bus25.out_vld, 0);
    @(negedge clk);
    check_output({tag, "/out_vld"}, bus25.out_vld, 1);
    for (int r = 0; r < N; r++) begin
      check_output($sformatf("%s/psum%0d", tag, r), $signed(bus25.psum_out[r*AW +: AW]), exp_psum);
      check_output($sformatf("%s/dout%0d", tag, r), $signed(bus25.dout[r*DW +: DW]), exp_dout);
    end
    bus25.psum_vld = 1'b0;
  endtask

  initial begin
    drive_idle();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset/out_vld", bus3.out_vld, 0);
    check_output("reset/psum_out", bus3.psum_out, 0);
    check_output("reset/dout", bus3.dout, 0);
    check_output("reset/map_out", bus3.map_out, 0);
    check_output("reset/tap_rdy", bus3.tap_rdy, 1);
    rst_n = 1'b1;

    // Forwarding is live even while clear is asserted.
    @(negedge clk);
    bus3.map_in  = 32'h04030201;
    bus3.map_vld = 4'b0101;
    bus3.clear   = 1'b1;
    @(negedge clk);
    check_output("fwd/map_out", bus3.map_out, 32'h04030201);
    check_output("fwd/map_out_vld", bus3.map_out_vld, 4'b0101);
    check_output("fwd/out_vld", bus3.out_vld, 0);
    drive_idle();

    window3("basic", 2, 3, 0, 0, 1'b0, 0, 18, 1);
    window3("chain", -1, 3, 100, 5, 1'b1, 2, 123, 7);
    window3("neg", -1, 3, 0, 0, 1'b0, 0, NEG_PSUM, NEG_DOUT);

    // One lane invalid: nothing may fire.
    @(negedge clk);
    apply_stimulus(1, 1, 0, 1'b0, 0);
    bus3.weight_vld = 1'b1;
    bus3.map_vld    = 4'b1011;
    repeat (3) begin
      @(negedge clk);
      check_output("gate/tap_rdy", bus3.tap_rdy, 1);
    end
    bus3.weight_vld = 1'b0;
    bus3.map_vld    = '0;
    window3("gate", 1, 1, 0, 0, 1'b0, 0, 3, 0);

    // Abort after two taps, then a clean window.
    @(negedge clk);
    apply_stimulus(1, 1, 0, 1'b0, 0);
    bus3.weight_vld = 1'b1;
    bus3.map_vld    = '1;
    repeat (2) @(negedge clk);
    bus3.weight_vld = 1'b0;
    bus3.clear      = 1'b1;
    @(negedge clk);
    bus3.clear = 1'b0;
    window3("clear", 1, 1, 0, 0, 1'b0, 0, 3, 0);

    // clear on the final fire discards the window.
    @(negedge clk);
    apply_stimulus(1, 1, 0, 1'b0, 0);
    bus3.weight_vld = 1'b1;
    bus3.map_vld    = '1;
    bus3.psum_vld   = 1'b1;
    repeat (2) @(negedge clk);
    bus3.clear = 1'b1;
    @(negedge clk);
    bus3.clear      = 1'b0;
    bus3.weight_vld = 1'b0;
    check_output("clrfinal/tap_rdy", bus3.tap_rdy, 1);
    repeat (2) begin
      @(negedge clk);
      check_output("clrfinal/out_vld", bus3.out_vld, 0);
    end
    bus3.psum_vld = 1'b0;
    window3("after_clr", 2, 3, 0, 0, 1'b0, 0, 18, 1);

    // Asynchronous reset while waiting in SUM.
    @(negedge clk);
    apply_stimulus(1, 1, 0, 1'b0, 0);
    bus3.weight_vld = 1'b1;
    bus3.map_vld    = '1;
    repeat (3) @(negedge clk);
    bus3.weight_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("arst/psum_out", $signed(bus3.psum_out[AW-1:0]), 0);
    check_output("arst/dout", bus3.dout, 0);
    check_output("arst/map_out", bus3.map_out, 0);
    check_output("arst/out_vld", bus3.out_vld, 0);
    check_output("arst/tap_rdy", bus3.tap_rdy, 1);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    bus3.psum_vld = 1'b1;
    @(negedge clk);
    check_output("arst/no_stale_out", bus3.out_vld, 0);
    bus3.psum_vld = 1'b0;
    window3("post_rst", 2, 3, 0, 0, 1'b0, 0, 18, 1);

    window25("satp", 127, 127, 8388607, 8388607, 127);
    window25("satn", -128, 127, -8388608, SATN_PSUM, SATN_DOUT);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
